// File: rtl/gorsel_bellek_yanitlayici.sv
// Memory-side responder: loads an input image, serves core reads/writes, then drains the result.
// Optional YAZ_KAPSAMA_EN: count each output pixel only once, on its first in-range write.
module gorsel_bellek_yanitlayici #(
  parameter int GENISLIK  = 150,
  parameter int YUKSEKLIK = 150,
  parameter int VERI_W    = 32,
  parameter int ADRES_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VERI_W-1:0]  yukle_veri,
  input  logic               yukle_gecerli,
  output logic               yukle_hazir,
  output logic               basla,
  input  logic [ADRES_W-1:0] oku_adres,
  output logic [VERI_W-1:0]  oku_veri,
  input  logic [VERI_W-1:0]  yaz_veri,
  input  logic [ADRES_W-1:0] yaz_adres,
  input  logic               yaz_gecerli,
  output logic [VERI_W-1:0]  cikis_veri,
  output logic               cikis_gecerli,
  input  logic               cikis_hazir,
  output logic               bitti,
  output logic               hata
);
  localparam int PIKSEL = GENISLIK * YUKSEKLIK;
  localparam int IDX_W  = (PIKSEL > 1) ? $clog2(PIKSEL) : 1;
  localparam logic [ADRES_W:0] PIKSEL_C = (ADRES_W + 1)'(PIKSEL);

  typedef enum logic [1:0] {YUKLE, ISLE, BOSALT, BITTI} durum_t;

  logic [VERI_W-1:0] girdi [PIKSEL];
  logic [VERI_W-1:0] cikti [PIKSEL];

  durum_t           durum_q, durum_d;
  logic [ADRES_W:0] yukle_sayac_q, yukle_sayac_d;
  logic [ADRES_W:0] yaz_sayac_q, yaz_sayac_d;
  logic [ADRES_W:0] cikis_sayac_q, cikis_sayac_d;
  logic             yukle_hazir_q, yukle_hazir_d;
  logic             basla_q, basla_d;
  logic             cikis_gecerli_q, cikis_gecerli_d;
  logic             bitti_q, bitti_d;
  logic             hata_q, hata_d;
  logic [VERI_W-1:0] oku_veri_q, cikis_veri_q;
`ifdef YAZ_KAPSAMA_EN
  logic [PIKSEL-1:0] yazildi_q, yazildi_d;
`endif

  logic girdi_yaz, cikti_yaz, oku_en, cikis_yukle;
  logic oku_ici, yaz_ici;
  logic [IDX_W-1:0] yukle_idx, oku_idx, yaz_idx, cikis_idx;

  assign yukle_idx = yukle_sayac_q[IDX_W-1:0];
  assign oku_idx   = oku_adres[IDX_W-1:0];
  assign yaz_idx   = yaz_adres[IDX_W-1:0];
  assign cikis_idx = cikis_sayac_q[IDX_W-1:0];
  assign oku_ici   = {1'b0, oku_adres} < PIKSEL_C;
  assign yaz_ici   = {1'b0, yaz_adres} < PIKSEL_C;

  always_comb begin
    durum_d         = durum_q;
    yukle_sayac_d   = yukle_sayac_q;
    yaz_sayac_d     = yaz_sayac_q;
    cikis_sayac_d   = cikis_sayac_q;
    cikis_gecerli_d = cikis_gecerli_q;
    hata_d          = hata_q;
    girdi_yaz       = 1'b0;
    cikti_yaz       = 1'b0;
    oku_en          = 1'b0;
    cikis_yukle     = 1'b0;
`ifdef YAZ_KAPSAMA_EN
    yazildi_d       = yazildi_q;
`endif
    case (durum_q)
      YUKLE: begin
        if (yukle_gecerli && yukle_hazir_q) begin
          girdi_yaz     = 1'b1;
          yukle_sayac_d = yukle_sayac_q + 1'b1;
          if (yukle_sayac_d == PIKSEL_C) begin
            durum_d = ISLE;
`ifdef YAZ_KAPSAMA_EN
            yazildi_d = '0;
`endif
          end
        end
      end
      ISLE: begin
        oku_en = 1'b1;
        if (!oku_ici) hata_d = 1'b1;
        if (yaz_gecerli) begin
          if (yaz_ici) begin
            cikti_yaz = 1'b1;
`ifdef YAZ_KAPSAMA_EN
            if (!yazildi_q[yaz_idx]) begin
              yazildi_d[yaz_idx] = 1'b1;
              yaz_sayac_d        = yaz_sayac_q + 1'b1;
            end
`else
            yaz_sayac_d = yaz_sayac_q + 1'b1;
`endif
          end else begin
            hata_d = 1'b1;
          end
        end
        if (yaz_sayac_d == PIKSEL_C) durum_d = BOSALT;
      end
      BOSALT: begin
        // cikis_sayac counts words fetched into the output register, not handshakes
        if (cikis_gecerli_q && cikis_hazir) begin
          cikis_gecerli_d = 1'b0;
          if (cikis_sayac_q == PIKSEL_C) durum_d = BITTI;
        end
        if ((!cikis_gecerli_q || cikis_hazir) && (cikis_sayac_q != PIKSEL_C)) begin
          cikis_yukle     = 1'b1;
          cikis_gecerli_d = 1'b1;
          cikis_sayac_d   = cikis_sayac_q + 1'b1;
        end
      end
      default: ;
    endcase
    yukle_hazir_d = (durum_d == YUKLE);
    basla_d       = (durum_d == ISLE);
    bitti_d       = (durum_d == BITTI);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum_q         <= YUKLE;
      yukle_sayac_q   <= '0;
      yaz_sayac_q     <= '0;
      cikis_sayac_q   <= '0;
      yukle_hazir_q   <= 1'b0;
      basla_q         <= 1'b0;
      cikis_gecerli_q <= 1'b0;
      bitti_q         <= 1'b0;
      hata_q          <= 1'b0;
`ifdef YAZ_KAPSAMA_EN
      yazildi_q       <= '0;
`endif
    end else begin
      durum_q         <= durum_d;
      yukle_sayac_q   <= yukle_sayac_d;
      yaz_sayac_q     <= yaz_sayac_d;
      cikis_sayac_q   <= cikis_sayac_d;
      yukle_hazir_q   <= yukle_hazir_d;
      basla_q         <= basla_d;
      cikis_gecerli_q <= cikis_gecerli_d;
      bitti_q         <= bitti_d;
      hata_q          <= hata_d;
`ifdef YAZ_KAPSAMA_EN
      yazildi_q       <= yazildi_d;
`endif
    end
  end

  // RAM contents survive reset, so the write ports carry no reset
  always_ff @(posedge clk) begin
    if (girdi_yaz) girdi[yukle_idx] <= yukle_veri;
  end

  always_ff @(posedge clk) begin
    if (cikti_yaz) cikti[yaz_idx] <= yaz_veri;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oku_veri_q   <= '0;
      cikis_veri_q <= '0;
    end else begin
      if (oku_en) oku_veri_q <= oku_ici ? girdi[oku_idx] : '0;
      if (cikis_yukle) cikis_veri_q <= cikti[cikis_idx];
    end
  end

  assign yukle_hazir   = yukle_hazir_q;
  assign basla         = basla_q;
  assign oku_veri      = oku_veri_q;
  assign cikis_veri    = cikis_veri_q;
  assign cikis_gecerli = cikis_gecerli_q;
  assign bitti         = bitti_q;
  assign hata          = hata_q;
endmodule
